// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment scanner with frame snapshot, blank window and blink.
// Optional: CLOCK_DISPLAY_LEADING_ZERO_BLANK_EN hides a zero hours-tens digit.
module clock_display_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] digits,
    input  logic [5:0]  blink_mask,
    input  logic        blink_pulse,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [23:0]   shadow;
    logic          phase;

    logic [3:0] dig;
    logic       blk;
    logic       lit;
    logic       slot_end;
    logic [5:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;

    assign slot_end = (cnt == CNT_LAST);

    always_comb begin
        dig = shadow[3:0];
        blk = blink_mask[0];
        case (idx)
            3'd1:    begin dig = shadow[7:4];   blk = blink_mask[1]; end
            3'd2:    begin dig = shadow[11:8];  blk = blink_mask[2]; end
            3'd3:    begin dig = shadow[15:12]; blk = blink_mask[3]; end
            3'd4:    begin dig = shadow[19:16]; blk = blink_mask[4]; end
            3'd5:    begin dig = shadow[23:20]; blk = blink_mask[5]; end
            default: begin dig = shadow[3:0];   blk = blink_mask[0]; end
        endcase
    end

    always_comb begin
        lit = (cnt >= CNT_BLANK) && !(phase && blk);
`ifdef CLOCK_DISPLAY_LEADING_ZERO_BLANK_EN
        if (idx == 3'd5 && shadow[23:20] == 4'd0)
            lit = 1'b0;
`endif
        an_d = lit ? ~(6'b000001 << idx) : 6'h3F;
        dp_d = !(lit && (idx == 3'd2 || idx == 3'd4));
    end

    always_comb begin
        seg_d = 7'h7F;
        case (dig)
            4'd0:    seg_d = 7'h40;
            4'd1:    seg_d = 7'h79;
            4'd2:    seg_d = 7'h24;
            4'd3:    seg_d = 7'h30;
            4'd4:    seg_d = 7'h19;
            4'd5:    seg_d = 7'h12;
            4'd6:    seg_d = 7'h02;
            4'd7:    seg_d = 7'h78;
            4'd8:    seg_d = 7'h00;
            4'd9:    seg_d = 7'h10;
            default: seg_d = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            idx    <= 3'd0;
            shadow <= 24'h0;
            phase  <= 1'b0;
            an     <= 6'h3F;
            seg    <= 7'h7F;
            dp     <= 1'b1;
        end else begin
            if (blink_pulse)
                phase <= ~phase;
            if (slot_end) begin
                cnt <= '0;
                // snapshot only at frame wrap so a frame never mixes two times
                if (idx == 3'd5) begin
                    idx    <= 3'd0;
                    shadow <= digits;
                end else begin
                    idx <= idx + 3'd1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=4, BLANK_CYC=1.
// Honours CLOCK_DISPLAY_LEADING_ZERO_BLANK_EN for the hours-tens check.
module tb_clock_display_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] digits;
    logic [5:0]  blink_mask;
    logic        blink_pulse;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_cmp = 0;
    int n_bad = 0;
    int e = 0;

    clock_display_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk),
        .rst(rst),
        .digits(digits),
        .blink_mask(blink_mask),
        .blink_pulse(blink_pulse),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] o, input logic [6:0] x);
        n_cmp++;
        assert (o === x) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
    endtask

    // output after edge e reflects frame f, slot i, count c where e = 24f+4i+c+1
    task automatic go(input int f, input int i, input int c);
        int target;
        target = 24 * f + 4 * i + c + 1;
        while (e < target) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    task automatic pulse();
        blink_pulse = 1'b1;
        @(posedge clk);
        e++;
        #1;
        blink_pulse = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        digits      = 24'($urandom);
        blink_mask  = 6'h00;
        blink_pulse = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("rst_an", {1'b0, an}, 7'h3F);
            chk("rst_seg", seg, 7'h7F);
            chk("rst_dp", {6'h0, dp}, 7'h01);
        end
        rst    = 1'b1;
        e      = 0;
        digits = 24'h123456;

        go(0, 0, 0); chk("f0_blank_an", {1'b0, an}, 7'h3F);
        go(0, 0, 1); chk("f0_i0_an", {1'b0, an}, 7'h3E);
        chk("f0_i0_seg", seg, 7'h40);
        go(0, 2, 1); chk("f0_i2_seg", seg, 7'h40);
        chk("f0_i2_dp", {6'h0, dp}, 7'h00);
        go(0, 5, 2); chk("f0_i5_an", {1'b0, an}, 7'h1F);
        chk("f0_i5_seg", seg, 7'h40);

        go(1, 0, 0); chk("f1_blank_an", {1'b0, an}, 7'h3F);
        go(1, 0, 1); chk("f1_i0_an", {1'b0, an}, 7'h3E);
        chk("f1_i0_seg", seg, 7'h02);
        chk("f1_i0_dp", {6'h0, dp}, 7'h01);
        go(1, 0, 3); chk("f1_i0_end_an", {1'b0, an}, 7'h3E);
        chk("f1_i0_end_seg", seg, 7'h02);
        go(1, 2, 0); chk("f1_i2_blank_dp", {6'h0, dp}, 7'h01);
        go(1, 2, 1); chk("f1_i2_an", {1'b0, an}, 7'h3B);
        chk("f1_i2_seg", seg, 7'h19);
        chk("f1_i2_dp", {6'h0, dp}, 7'h00);
        go(1, 3, 1); chk("f1_i3_seg", seg, 7'h30);
        digits = 24'h999999;
        go(1, 4, 2); chk("f1_i4_an", {1'b0, an}, 7'h2F);
        chk("f1_i4_seg", seg, 7'h24);
        chk("f1_i4_dp", {6'h0, dp}, 7'h00);
        go(1, 5, 1); chk("f1_i5_an", {1'b0, an}, 7'h1F);
        chk("f1_i5_seg", seg, 7'h79);

        go(2, 0, 1); chk("f2_i0_seg", seg, 7'h10);
        go(2, 3, 2); chk("f2_i3_seg", seg, 7'h10);
        digits = 24'h12345B;
        go(2, 5, 3); chk("f2_i5_seg", seg, 7'h10);
        chk("f2_i5_an", {1'b0, an}, 7'h1F);
        blink_mask = 6'b110000;
        pulse();

        go(3, 0, 1); chk("f3_bad_an", {1'b0, an}, 7'h3E);
        chk("f3_bad_seg", seg, 7'h7F);
        go(3, 1, 1); chk("f3_i1_an", {1'b0, an}, 7'h3D);
        chk("f3_i1_seg", seg, 7'h12);
        go(3, 3, 1); chk("f3_i3_an", {1'b0, an}, 7'h37);
        digits = 24'h012345;
        go(3, 4, 1); chk("f3_blink4_an", {1'b0, an}, 7'h3F);
        chk("f3_blink4_dp", {6'h0, dp}, 7'h01);
        go(3, 5, 2); chk("f3_blink5_an", {1'b0, an}, 7'h3F);
        go(3, 5, 3);
        pulse();

        go(4, 0, 1); chk("f4_i0_seg", seg, 7'h12);
        go(4, 4, 1); chk("f4_i4_an", {1'b0, an}, 7'h2F);
        chk("f4_i4_seg", seg, 7'h79);
        chk("f4_i4_dp", {6'h0, dp}, 7'h00);
        go(4, 5, 1);
`ifdef CLOCK_DISPLAY_LEADING_ZERO_BLANK_EN
        chk("f4_lz_an", {1'b0, an}, 7'h3F);
`else
        chk("f4_lz_an", {1'b0, an}, 7'h1F);
        chk("f4_lz_seg", seg, 7'h40);
`endif
        chk("f4_lz_dp", {6'h0, dp}, 7'h01);

        go(5, 2, 2);
        chk("f5_i2_an", {1'b0, an}, 7'h3B);
        rst = 1'b0;
        #1;
        chk("mid_rst_an", {1'b0, an}, 7'h3F);
        chk("mid_rst_seg", seg, 7'h7F);
        chk("mid_rst_dp", {6'h0, dp}, 7'h01);
        #1;
        rst        = 1'b1;
        blink_mask = 6'h00;
        e          = 0;
        go(0, 0, 0); chk("re_blank_an", {1'b0, an}, 7'h3F);
        go(0, 0, 1); chk("re_i0_an", {1'b0, an}, 7'h3E);
        chk("re_i0_seg", seg, 7'h40);
        go(0, 4, 1); chk("re_i4_an", {1'b0, an}, 7'h2F);
        chk("re_i4_seg", seg, 7'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
